// File: rtl/jtag_master_seq.sv
// Command-driven JTAG TAP master: IR/DR scans, TAP reset and Run-Test/Idle clocking,
// with automatic TMS navigation from/to Run-Test/Idle and a TCK divider.
module jtag_master_seq #(
  parameter int IR_WIDTH = 10,
  parameter int DR_MAX   = 32,
  parameter int CLK_DIV  = 2,
  localparam int LW = $clog2(DR_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LW-1:0]     cmd_len,
  input  logic [DR_MAX-1:0] cmd_tdi,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_tdo,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [1:0] OP_IR  = 2'b00;
  localparam logic [1:0] OP_DR  = 2'b01;
  localparam logic [1:0] OP_TLR = 2'b10;

  localparam logic [2:0] ST_TLR   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PRE   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_POST  = 3'd4;
  localparam logic [2:0] ST_RTI   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam int SW     = (IR_WIDTH > DR_MAX) ? IR_WIDTH : DR_MAX;
  localparam int SEGMAX = (SW > 6) ? SW : 6;
  localparam int IW     = $clog2(SEGMAX + 1);
  localparam int PW     = $clog2(SW);
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Index of the final pulse within each TMS segment.
  function automatic logic [IW-1:0] seg_last(input logic [2:0] st, input logic [1:0] op,
                                             input logic [IW-1:0] len);
    logic [IW-1:0] last;
    case (st)
      ST_TLR:   last = IW'(5);
      ST_PRE:   last = (op == OP_IR) ? IW'(3) : IW'(2);
      ST_SHIFT: last = (op == OP_IR) ? IW'(IR_WIDTH - 1) : len - IW'(1);
      ST_POST:  last = IW'(1);
      ST_RTI:   last = len - IW'(1);
      default:  last = '0;
    endcase
    return last;
  endfunction

  function automatic logic tms_of(input logic [2:0] st, input logic [1:0] op,
                                  input logic [IW-1:0] idx, input logic [IW-1:0] last);
    logic t;
    case (st)
      ST_TLR:   t = (idx != last);
      ST_PRE:   t = (op == OP_IR) ? (idx < IW'(2)) : (idx == '0);
      ST_SHIFT: t = (idx == last);
      ST_POST:  t = (idx == '0);
      ST_RTI:   t = 1'b0;
      default:  t = 1'b1;
    endcase
    return t;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              arm_q, arm_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic [1:0]        op_q, op_d;
  logic [IW-1:0]     len_q, len_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [SW-1:0]     cap_q, cap_d;
  logic              rsp_en_q, rsp_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DR_MAX-1:0] rsp_tdo_q, rsp_tdo_d;

  logic [IW-1:0] last_s, adv_idx_s, pos_idx_s, len_clamp_s;
  logic [2:0]    adv_state_s, pos_state_s;
  logic          adv_end_s, pos_tms_s, pos_tdi_s;

  // Position of the next pulse; arm_q means the current position has not started yet.
  always_comb begin
    len_clamp_s = (cmd_len > LW'(DR_MAX)) ? IW'(DR_MAX) : IW'(cmd_len);
    last_s      = seg_last(state_q, op_q, len_q);
    adv_state_s = state_q;
    adv_idx_s   = idx_q + IW'(1);
    adv_end_s   = 1'b0;
    if (idx_q == last_s) begin
      adv_idx_s = '0;
      case (state_q)
        ST_PRE:   adv_state_s = ST_SHIFT;
        ST_SHIFT: adv_state_s = ST_POST;
        default:  adv_end_s   = 1'b1;
      endcase
    end else begin
      adv_end_s = 1'b0;
    end
    pos_state_s = arm_q ? state_q : adv_state_s;
    pos_idx_s   = arm_q ? idx_q : adv_idx_s;
    pos_tms_s   = tms_of(pos_state_s, op_q, pos_idx_s, seg_last(pos_state_s, op_q, len_q));
    pos_tdi_s   = (pos_state_s == ST_SHIFT) ? sh_q[pos_idx_s[PW-1:0]] : 1'b0;
  end

  // Command accept, TCK pulse timing and completion.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    arm_d       = arm_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    op_d        = op_q;
    len_d       = len_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    rsp_en_d    = rsp_en_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = rsp_tdo_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d     = cmd_op;
          len_d    = len_clamp_s;
          sh_d     = SW'(cmd_tdi);
          cap_d    = '0;
          rsp_en_d = 1'b1;
          ready_d  = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          arm_d    = 1'b1;
          case (cmd_op)
            OP_IR:   state_d = ST_PRE;
            OP_DR:   state_d = (len_clamp_s == '0) ? ST_DONE : ST_PRE;
            OP_TLR:  state_d = ST_TLR;
            default: state_d = (len_clamp_s == '0) ? ST_DONE : ST_RTI;
          endcase
        end else begin
          arm_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        ready_d     = 1'b1;
        arm_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_tdo_d   = '0;
      end
      ST_TLR, ST_PRE, ST_SHIFT, ST_POST, ST_RTI: begin
        if (arm_q) begin
          arm_d = 1'b0;
          tck_d = 1'b0;
          cnt_d = '0;
          tms_d = pos_tms_s;
          tdi_d = pos_tdi_s;
        end else if (cnt_q != DW'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + DW'(1);
        end else if (!tck_q) begin
          tck_d = 1'b1;
          cnt_d = '0;
          if (state_q == ST_SHIFT) begin
            cap_d[idx_q[PW-1:0]] = tdo;
          end else begin
            cap_d = cap_q;
          end
        end else begin
          // Falling edge: either the next pulse starts here or the command completes.
          tck_d = 1'b0;
          cnt_d = '0;
          if (adv_end_s) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            tdi_d       = 1'b0;
            rsp_valid_d = rsp_en_q;
            rsp_tdo_d   = rsp_en_q ? cap_q[DR_MAX-1:0] : rsp_tdo_q;
          end else begin
            state_d = adv_state_s;
            idx_d   = adv_idx_s;
            tms_d   = pos_tms_s;
            tdi_d   = pos_tdi_s;
          end
        end
      end
      default: begin
        state_d  = ST_TLR;
        idx_d    = '0;
        cnt_d    = '0;
        arm_d    = 1'b1;
        tck_d    = 1'b0;
        tms_d    = 1'b1;
        tdi_d    = 1'b0;
        ready_d  = 1'b0;
        rsp_en_d = 1'b0;
      end
    endcase
    busy_d = ~ready_d;
  end

  // Registered state, pins and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_TLR;
      idx_q       <= '0;
      cnt_q       <= '0;
      arm_q       <= 1'b1;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      op_q        <= OP_TLR;
      len_q       <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      rsp_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      arm_q       <= arm_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      op_q        <= op_d;
      len_q       <= len_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      rsp_en_q    <= rsp_en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_master_seq.sv
// Directed bench for jtag_master_seq with TDO looped back to TDI.
module tb_jtag_master_seq;
  localparam int LW = 6;
  localparam logic [1:0] OP_IR = 2'b00, OP_DR = 2'b01, OP_TLR = 2'b10, OP_RTI = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [LW-1:0] cmd_len = 6'd0;
  logic [31:0]   cmd_tdi = 32'h0;
  logic          cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [31:0]   rsp_tdo;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rsp_seen = 0;
  logic tms_log[$];

  jtag_master_seq #(.IR_WIDTH(10), .DR_MAX(32), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid),
    .rsp_tdo(rsp_tdo), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  assign tdo = tdi;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;
  end

  always @(posedge tck) tms_log.push_back(tms);

  function automatic logic [63:0] tms_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    return v;
  endfunction

  task automatic wait_ready(output int waited);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [LW-1:0] len, input logic [31:0] d,
                         output int lat, output logic [31:0] rtdo, output logic rdy, output logic tk);
    int w, k;
    wait_ready(w);
    cmd_op = op; cmd_len = len; cmd_tdi = d; cmd_valid = 1'b1;
    tms_log.delete();
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    cmd_valid = 1'b0;
    w = 0;
    while (rsp_valid !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    lat = (rsp_valid === 1'b1) ? cyc - k : -1;
    rtdo = rsp_tdo; rdy = cmd_ready; tk = tck;
  endtask

  task automatic test_reset;
    int w, r, s, lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tck, tms, tdi, cmd_ready, busy, rsp_valid} !== 6'b010010) begin
      n_fail++; $display("FAIL reset_pins: got %b expected 010010", {tck, tms, tdi, cmd_ready, busy, rsp_valid});
    end
    n_cmp++;
    if (rsp_tdo !== 32'h0) begin n_fail++; $display("FAIL reset_tdo: got %h expected 0", rsp_tdo); end
    tms_log.delete(); s = rsp_seen; r = cyc;
    rst_n = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    lat = (cmd_ready === 1'b1) ? cyc - r : -1;
    n_cmp++;
    if (lat !== 25) begin n_fail++; $display("FAIL boot_latency: got %0d expected 25", lat); end
    n_cmp++;
    if (tms_log.size() !== 6 || tms_vec() !== 64'h1F) begin
      n_fail++; $display("FAIL boot_tms: got %0d pulses %h expected 6 pulses 1f", tms_log.size(), tms_vec());
    end
    n_cmp++;
    if (rsp_seen !== s || busy !== 1'b0) begin
      n_fail++; $display("FAIL boot_rsp: got rsp %0d busy %b expected rsp 0 busy 0", rsp_seen - s, busy);
    end
  endtask

  task automatic test_ir_scan;
    int lat; logic [31:0] t; logic rdy, tk;
    run_cmd(OP_IR, 6'd0, 32'h2A5, lat, t, rdy, tk);
    n_cmp++;
    if (lat !== 65) begin n_fail++; $display("FAIL ir_latency: got %0d expected 65", lat); end
    n_cmp++;
    if (t !== 32'h2A5) begin n_fail++; $display("FAIL ir_tdo: got %h expected 2a5", t); end
    n_cmp++;
    if (tms_log.size() !== 16 || tms_vec() !== 64'h6003) begin
      n_fail++; $display("FAIL ir_tms: got %0d pulses %h expected 16 pulses 6003", tms_log.size(), tms_vec());
    end
    n_cmp++;
    if (rdy !== 1'b1 || tk !== 1'b0) begin
      n_fail++; $display("FAIL ir_end: got ready %b tck %b expected ready 1 tck 0", rdy, tk);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_tdo !== 32'h2A5) begin
      n_fail++; $display("FAIL ir_hold: got valid %b tdo %h expected valid 0 tdo 2a5", rsp_valid, rsp_tdo);
    end
  endtask

  task automatic test_idle_clocks;
    int lat; logic [31:0] t; logic rdy, tk;
    run_cmd(OP_RTI, 6'd3, 32'hFFFFFFFF, lat, t, rdy, tk);
    n_cmp++;
    if (lat !== 13) begin n_fail++; $display("FAIL rti_latency: got %0d expected 13", lat); end
    n_cmp++;
    if (tms_log.size() !== 3 || tms_vec() !== 64'h0 || t !== 32'h0) begin
      n_fail++; $display("FAIL rti_pulses: got %0d pulses tms %h tdo %h expected 3 pulses tms 0 tdo 0",
                         tms_log.size(), tms_vec(), t);
    end
  endtask

  task automatic test_back_to_back;
    int w, k, f, lat;
    wait_ready(w);
    cmd_op = OP_DR; cmd_len = 6'd32; cmd_tdi = 32'hDEADBEEF; cmd_valid = 1'b1;
    tms_log.delete();
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    cmd_len = 6'd8; cmd_tdi = 32'h000000A5;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b expected 0", cmd_ready); end
    w = 0;
    while (rsp_valid !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    f = cyc;
    lat = (rsp_valid === 1'b1) ? f - k : -1;
    n_cmp++;
    if (lat !== 149) begin n_fail++; $display("FAIL dr32_latency: got %0d expected 149", lat); end
    n_cmp++;
    if (rsp_tdo !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dr32_tdo: got %h expected deadbeef", rsp_tdo); end
    n_cmp++;
    if (tms_log.size() !== 37 || tms_vec() !== 64'hC_0000_0001) begin
      n_fail++; $display("FAIL dr32_tms: got %0d pulses %h expected 37 pulses c00000001", tms_log.size(), tms_vec());
    end
    tms_log.delete();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got ready %b expected 0", cmd_ready); end
    w = 0;
    while (rsp_valid !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    lat = (rsp_valid === 1'b1) ? cyc - f : -1;
    n_cmp++;
    if (lat !== 54) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 54", lat); end
    n_cmp++;
    if (rsp_tdo !== 32'hA5 || tms_log.size() !== 13 || tms_vec() !== 64'hC01) begin
      n_fail++; $display("FAIL b2b_dr8: got tdo %h %0d pulses tms %h expected tdo a5 13 pulses tms c01",
                         rsp_tdo, tms_log.size(), tms_vec());
    end
  endtask

  task automatic test_zero_len;
    int lat; logic [31:0] t; logic rdy, tk;
    run_cmd(OP_DR, 6'd0, 32'hFFFFFFFF, lat, t, rdy, tk);
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (t !== 32'h0 || tms_log.size() !== 0 || rdy !== 1'b1) begin
      n_fail++; $display("FAIL zero_result: got tdo %h %0d pulses ready %b expected tdo 0 0 pulses ready 1",
                         t, tms_log.size(), rdy);
    end
  endtask

  task automatic test_tap_reset;
    int lat; logic [31:0] t; logic rdy, tk;
    run_cmd(OP_TLR, 6'd5, 32'h12345678, lat, t, rdy, tk);
    n_cmp++;
    if (lat !== 25) begin n_fail++; $display("FAIL tlr_latency: got %0d expected 25", lat); end
    n_cmp++;
    if (tms_log.size() !== 6 || tms_vec() !== 64'h1F || t !== 32'h0) begin
      n_fail++; $display("FAIL tlr_pulses: got %0d pulses tms %h tdo %h expected 6 pulses tms 1f tdo 0",
                         tms_log.size(), tms_vec(), t);
    end
  endtask

  task automatic test_clamp;
    int lat; logic [31:0] t; logic rdy, tk;
    run_cmd(OP_DR, 6'd40, 32'h12345678, lat, t, rdy, tk);
    n_cmp++;
    if (lat !== 149 || t !== 32'h12345678) begin
      n_fail++; $display("FAIL clamp_result: got lat %0d tdo %h expected lat 149 tdo 12345678", lat, t);
    end
    n_cmp++;
    if (tms_log.size() !== 37 || tms_vec() !== 64'hC_0000_0001) begin
      n_fail++; $display("FAIL clamp_tms: got %0d pulses %h expected 37 pulses c00000001", tms_log.size(), tms_vec());
    end
  endtask

  task automatic test_abort;
    int w, r, s, lat;
    wait_ready(w);
    cmd_op = OP_DR; cmd_len = 6'd32; cmd_tdi = 32'hCAFEF00D; cmd_valid = 1'b1;
    tms_log.delete();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    s = rsp_seen;
    w = 0;
    while (tms_log.size() < 8 && w < 500) begin @(negedge clk); w++; end
    n_cmp++;
    if (tms_log.size() !== 8 || tck !== 1'b1) begin
      n_fail++; $display("FAIL abort_reach: got %0d pulses tck %b expected 8 pulses tck 1", tms_log.size(), tck);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tck, tms, tdi, cmd_ready, busy, rsp_valid} !== 6'b010010 || rsp_tdo !== 32'h0) begin
      n_fail++; $display("FAIL abort_pins: got %b tdo %h expected 010010 tdo 0",
                         {tck, tms, tdi, cmd_ready, busy, rsp_valid}, rsp_tdo);
    end
    repeat (3) @(negedge clk);
    tms_log.delete(); r = cyc;
    rst_n = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    lat = (cmd_ready === 1'b1) ? cyc - r : -1;
    n_cmp++;
    if (lat !== 25 || tms_log.size() !== 6 || tms_vec() !== 64'h1F) begin
      n_fail++; $display("FAIL abort_reboot: got lat %0d %0d pulses tms %h expected lat 25 6 pulses tms 1f",
                         lat, tms_log.size(), tms_vec());
    end
    n_cmp++;
    if (rsp_seen !== s) begin n_fail++; $display("FAIL abort_rsp: got %0d strobes expected 0", rsp_seen - s); end
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_idle_clocks();
    test_back_to_back();
    test_zero_len();
    test_tap_reset();
    test_clamp();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
